// File: rtl/if_id_buf_if.sv
// rtl/if_id_buf_if.sv - fetch/decode handshake bundle for the if_id_buf fetch-to-decode buffer
interface if_id_buf_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;
  logic              if_ready;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic [CNT_W-1:0]  occupancy;

  // master: the fetch/decode pipeline around the buffer
  modport master (
    output if_pc, if_inst, if_valid, stall, flush,
    input  if_ready, id_pc, id_inst, id_valid, occupancy
  );

  // slave: the buffer itself
  modport slave (
    input  if_pc, if_inst, if_valid, stall, flush,
    output if_ready, id_pc, id_inst, id_valid, occupancy
  );
endinterface

// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - in-order fetch-to-decode FIFO; IF_ID_BUF_STAT_EN adds stall/flush statistics counters
module if_id_buf #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IF_ID_BUF_STAT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flushed_insts,
`endif
  if_id_buf_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic              valid;
  logic              ready;
  logic              enq;
  logic              deq;

  // ready comes only from registered state, so a full buffer never passes through
  assign valid = (state != S_EMPTY);
  assign ready = !rst && (state != S_FULL);
  assign enq   = bus.if_valid && ready;
  assign deq   = valid && !bus.stall;

  always_comb begin
    cnt_next = cnt;
    if (bus.flush) begin
      cnt_next = '0;
    end else if (enq && !deq) begin
      cnt_next = cnt + CNT_W'(1);
    end else if (deq && !enq) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_next = S_PARTIAL;
    if (cnt_next == '0) begin
      state_next = S_EMPTY;
    end else if (cnt_next == FULL_CNT) begin
      state_next = S_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
      cnt   <= '0;
      wp    <= '0;
      rp    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (bus.flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (enq) begin
          pc_mem[wp]   <= bus.if_pc;
          inst_mem[wp] <= bus.if_inst;
          wp           <= wp + PTR_W'(1);
        end
        if (deq) begin
          rp <= rp + PTR_W'(1);
        end
      end
    end
  end

`ifdef IF_ID_BUF_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      flushed_insts <= '0;
    end else begin
      if (valid && bus.stall) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (bus.flush) begin
        flushed_insts <= flushed_insts + 32'(cnt);
      end
    end
  end
`endif

  // an empty slot reads as all-zero, which decodes as a nop
  assign bus.if_ready  = ready;
  assign bus.id_valid  = valid;
  assign bus.id_pc     = valid ? pc_mem[rp]   : '0;
  assign bus.id_inst   = valid ? inst_mem[rp] : '0;
  assign bus.occupancy = cnt;
endmodule

// File: tb/tb_if_id_buf.sv
// tb/tb_if_id_buf.sv - directed self-checking bench for if_id_buf
module tb_if_id_buf;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   idx;
  int   nout;
  logic [31:0] got [8];
`ifdef IF_ID_BUF_STAT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flushed_insts;
`endif

  if_id_buf_if #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) bus ();

  if_id_buf #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef IF_ID_BUF_STAT_EN
    .stall_cycles  (stall_cycles),
    .flushed_insts (flushed_insts),
`endif
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = inst;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_id_pc", 64'(bus.id_pc), 64'd0);
    chk("rst_id_inst", 64'(bus.id_inst), 64'd0);
    chk("rst_occ", 64'(bus.occupancy), 64'd0);
    chk("rst_if_ready", 64'(bus.if_ready), 64'd0);

    // streaming with no stall
    rst = 1'b0;
    drive(1'b1, 32'h0, 32'h34011100, 1'b0, 1'b0);
    #1;
    chk("post_rst_ready", 64'(bus.if_ready), 64'd1);
    tick();
    chk("s0_pc", 64'(bus.id_pc), 64'h0);
    chk("s0_inst", 64'(bus.id_inst), 64'h34011100);
    chk("s0_occ", 64'(bus.occupancy), 64'd1);
    drive(1'b1, 32'h4, 32'h34020020, 1'b0, 1'b0);
    tick();
    chk("s1_pc", 64'(bus.id_pc), 64'h4);
    chk("s1_inst", 64'(bus.id_inst), 64'h34020020);
    chk("s1_occ", 64'(bus.occupancy), 64'd1);
    chk("s1_ready", 64'(bus.if_ready), 64'd1);
    drive(1'b1, 32'h8, 32'h3403ff00, 1'b0, 1'b0);
    tick();
    chk("s2_pc", 64'(bus.id_pc), 64'h8);
    chk("s2_inst", 64'(bus.id_inst), 64'h3403ff00);
    chk("s2_occ", 64'(bus.occupancy), 64'd1);
    chk("s2_ready", 64'(bus.if_ready), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("drain_valid", 64'(bus.id_valid), 64'd0);
    chk("drain_pc_nop", 64'(bus.id_pc), 64'd0);

    // fill to full under stall
    drive(1'b1, 32'h10, 32'h24100010, 1'b1, 1'b0);
    tick();
    chk("f0_pc", 64'(bus.id_pc), 64'h10);
    drive(1'b1, 32'h14, 32'h24100014, 1'b1, 1'b0);
    tick();
    chk("full_occ", 64'(bus.occupancy), 64'd2);
    chk("full_ready", 64'(bus.if_ready), 64'd0);
    chk("full_pc", 64'(bus.id_pc), 64'h10);
    drive(1'b1, 32'h18, 32'h24100018, 1'b1, 1'b0);
    tick();
    chk("full_hold_occ", 64'(bus.occupancy), 64'd2);
    chk("full_hold_pc", 64'(bus.id_pc), 64'h10);
    chk("full_hold_inst", 64'(bus.id_inst), 64'h24100010);

    // one unstalled cycle while 0x18 is still offered: no pass-through at full
    bus.stall = 1'b0;
    tick();
    chk("dq_pc", 64'(bus.id_pc), 64'h14);
    chk("dq_occ", 64'(bus.occupancy), 64'd1);
    chk("dq_ready", 64'(bus.if_ready), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("dq_empty", 64'(bus.id_valid), 64'd0);

    // flush while full with a fetch offered
    drive(1'b1, 32'h20, 32'h24100020, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h24, 32'h24100024, 1'b1, 1'b0);
    tick();
    chk("pre_flush_occ", 64'(bus.occupancy), 64'd2);
    drive(1'b1, 32'h28, 32'h24100028, 1'b0, 1'b1);
    tick();
    chk("fl_valid", 64'(bus.id_valid), 64'd0);
    chk("fl_pc", 64'(bus.id_pc), 64'd0);
    chk("fl_inst", 64'(bus.id_inst), 64'd0);
    chk("fl_occ", 64'(bus.occupancy), 64'd0);

    // flush while partial: enq and deq offered in the same cycle are both ignored
    drive(1'b1, 32'h30, 32'h24100030, 1'b1, 1'b0);
    tick();
    chk("fl2_pre_occ", 64'(bus.occupancy), 64'd1);
    drive(1'b1, 32'h34, 32'h24100034, 1'b0, 1'b1);
    tick();
    chk("fl2_occ", 64'(bus.occupancy), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("fl2_not_stored", 64'(bus.id_valid), 64'd0);
`ifdef IF_ID_BUF_STAT_EN
    chk("stat_flushed", 64'(flushed_insts), 64'd3);
`endif

    // wrap-around: fetch holds pc while not ready, stall alternates
    idx  = 0;
    nout = 0;
    for (int c = 0; c < 40 && nout < 7; c++) begin
      drive(idx < 7, 32'(32'h40 + 4 * idx), 32'(32'h24000000 + idx), (c % 2) == 1, 1'b0);
      if (bus.id_valid && !bus.stall) begin
        got[nout] = bus.id_pc;
        nout++;
      end
      if (bus.if_valid && bus.if_ready) idx++;
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("wrap_count", 64'(nout), 64'd7);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("wrap_order_%0d", k), 64'(got[k]), 64'(32'h40 + 4 * k));
    end
    chk("wrap_end_occ", 64'(bus.occupancy), 64'd0);

    // reset mid-operation with two entries buffered
    drive(1'b1, 32'h60, 32'h24100060, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h64, 32'h24100064, 1'b1, 1'b0);
    tick();
    chk("mr_pre_occ", 64'(bus.occupancy), 64'd2);
    bus.stall = 1'b0;
    tick();
    drive(1'b1, 32'h68, 32'h24100068, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_ready_in_rst", 64'(bus.if_ready), 64'd0);
    tick();
    chk("mr_valid", 64'(bus.id_valid), 64'd0);
    chk("mr_occ", 64'(bus.occupancy), 64'd0);
    chk("mr_pc", 64'(bus.id_pc), 64'd0);
    chk("mr_ready", 64'(bus.if_ready), 64'd0);
`ifdef IF_ID_BUF_STAT_EN
    chk("mr_stall_cycles", 64'(stall_cycles), 64'd0);
    chk("mr_flushed", 64'(flushed_insts), 64'd0);
`endif
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("mr_after_valid", 64'(bus.id_valid), 64'd0);
    chk("mr_after_occ", 64'(bus.occupancy), 64'd0);
    chk("mr_after_ready", 64'(bus.if_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
